// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 frame-buffer burst schedulers (read and write side).
package ddr3_pkg;

  localparam int          BEAT_BYTES      = 8;
  localparam logic [31:0] DEF_ADDR_BASE   = 32'h0000_0000;
  localparam int          DEF_FRAME_BEATS = 76800;
  localparam int          DEF_BURST_LEN   = 64;
  localparam int          DEF_FIFO_DEPTH  = 1024;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ACK,
    WAIT_DONE,
    ADVANCE
  } burst_state_t;

  // Length of the next burst: a full burst, or whatever remains of the frame.
  function automatic logic [9:0] burst_len_min(input logic [23:0] beats_left,
                                               input logic [9:0]  burst_len);
    if (beats_left < {14'd0, burst_len})
      return beats_left[9:0];
    else
      return burst_len;
  endfunction

endpackage

// File: rtl/ddr3_rd_burst_ctrl.sv
// Read-side burst scheduler: walks the frame linearly and issues one read burst
// whenever the downstream FIFO has room for a full burst, wrapping at frame end.
module ddr3_rd_burst_ctrl
  import ddr3_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE,
  parameter int          FRAME_BEATS = DEF_FRAME_BEATS,
  parameter int          BURST_LEN   = DEF_BURST_LEN,
  parameter int          FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        rd_en,
  input  logic        frame_restart,
  input  logic [10:0] rd_fifo_cnt,
  input  logic        RD_READY,
  input  logic        RD_DONE,
  output logic        RD_START,
  output logic [31:0] RD_ADRS,
  output logic [9:0]  RD_LEN,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [23:0] FRAME_BEATS_W = 24'(FRAME_BEATS);
  localparam logic [9:0]  BURST_LEN_W   = 10'(BURST_LEN);
  localparam logic [11:0] FIFO_THRESH   = 12'(FIFO_DEPTH - BURST_LEN);
  localparam int          BEAT_SHIFT    = $clog2(BEAT_BYTES);

  burst_state_t state;
  logic [31:0]  cur_adrs;
  logic [23:0]  beats_left;
  logic         restart_pend;

  logic         fifo_room;
  logic [9:0]   next_len;
  logic [23:0]  beats_after;
  logic [31:0]  next_adrs;

  // RD_LEN is frozen for the whole burst, so the advance arithmetic can use it directly.
  assign fifo_room   = {1'b0, rd_fifo_cnt} <= FIFO_THRESH;
  assign next_len    = burst_len_min(beats_left, BURST_LEN_W);
  assign beats_after = beats_left - {14'd0, RD_LEN};
  assign next_adrs   = cur_adrs + ({22'd0, RD_LEN} << BEAT_SHIFT);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state        <= IDLE;
      cur_adrs     <= ADDR_BASE;
      beats_left   <= FRAME_BEATS_W;
      restart_pend <= 1'b0;
      RD_START     <= 1'b0;
      RD_ADRS      <= ADDR_BASE;
      RD_LEN       <= BURST_LEN_W;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      RD_START   <= 1'b0;
      frame_done <= 1'b0;
      if (frame_restart)
        restart_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (restart_pend) begin
            cur_adrs     <= ADDR_BASE;
            beats_left   <= FRAME_BEATS_W;
            restart_pend <= frame_restart;
          end else if (rd_en && RD_READY && fifo_room) begin
            RD_ADRS  <= cur_adrs;
            RD_LEN   <= next_len;
            RD_START <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end

        ISSUE: state <= ACK;

        // The master signals acceptance by leaving its idle state.
        ACK: begin
          if (!RD_READY)
            state <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (RD_DONE)
            state <= ADVANCE;
        end

        ADVANCE: begin
          if (beats_after == 24'd0) begin
            frame_done <= 1'b1;
            cur_adrs   <= ADDR_BASE;
            beats_left <= FRAME_BEATS_W;
          end else begin
            cur_adrs   <= next_adrs;
            beats_left <= beats_after;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_rd_burst_ctrl.sv
// Directed bench for ddr3_rd_burst_ctrl: a full-size frame instance (0) and a
// 100-beat frame instance (1) exercising the partial final burst.
module tb_ddr3_rd_burst_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  rd_en;
  logic [1:0]  frame_restart;
  logic [10:0] fifo_cnt [2];
  logic [1:0]  m_ready;
  logic [1:0]  m_done;
  logic [1:0]  rd_start;
  logic [31:0] rd_adrs [2];
  logic [9:0]  rd_len [2];
  logic [1:0]  frame_done;
  logic [1:0]  busy;

  int          burst_lat = 10;
  int          m_cnt [2];

  int          start_cnt [2];
  logic [31:0] log_adrs [2][64];
  logic [9:0]  log_len [2][64];
  int          width_err [2];
  int          busy_miss [2];
  int          stab_err [2];
  int          fd_cnt [2];
  int          fd_width_err [2];
  logic [1:0]  prev_start;
  logic [1:0]  prev_fd;
  logic [31:0] held_adrs [2];
  logic [9:0]  held_len [2];

  int          n_checks = 0;
  int          n_fail = 0;

  always #5 aclk = ~aclk;

  ddr3_rd_burst_ctrl #(
    .ADDR_BASE(32'h0000_0000), .FRAME_BEATS(76800), .BURST_LEN(64), .FIFO_DEPTH(1024)
  ) dut_full (
    .ACLK(aclk), .ARESETN(aresetn), .rd_en(rd_en[0]), .frame_restart(frame_restart[0]),
    .rd_fifo_cnt(fifo_cnt[0]), .RD_READY(m_ready[0]), .RD_DONE(m_done[0]),
    .RD_START(rd_start[0]), .RD_ADRS(rd_adrs[0]), .RD_LEN(rd_len[0]),
    .frame_done(frame_done[0]), .busy(busy[0])
  );

  ddr3_rd_burst_ctrl #(
    .ADDR_BASE(32'h0000_0000), .FRAME_BEATS(100), .BURST_LEN(64), .FIFO_DEPTH(1024)
  ) dut_part (
    .ACLK(aclk), .ARESETN(aresetn), .rd_en(rd_en[1]), .frame_restart(frame_restart[1]),
    .rd_fifo_cnt(fifo_cnt[1]), .RD_READY(m_ready[1]), .RD_DONE(m_done[1]),
    .RD_START(rd_start[1]), .RD_ADRS(rd_adrs[1]), .RD_LEN(rd_len[1]),
    .frame_done(frame_done[1]), .busy(busy[1])
  );

  // Read-master model: accepts a request, stays busy burst_lat cycles, pulses done.
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ready[k] = 1'b1;
      m_done[k]  = 1'b0;
      m_cnt[k]   = 0;
    end
    forever begin
      @(negedge aclk);
      for (int k = 0; k < 2; k++) begin
        if (!aresetn) begin
          m_ready[k] = 1'b1;
          m_done[k]  = 1'b0;
          m_cnt[k]   = 0;
        end else if (m_done[k]) begin
          m_done[k]  = 1'b0;
          m_ready[k] = 1'b1;
        end else if (!m_ready[k]) begin
          if (m_cnt[k] == 0) m_done[k] = 1'b1;
          else m_cnt[k] = m_cnt[k] - 1;
        end else if (rd_start[k]) begin
          m_ready[k] = 1'b0;
          m_cnt[k]   = burst_lat;
        end
      end
    end
  end

  // Monitor: logs every request and tallies protocol anomalies for the tests to inspect.
  initial begin
    for (int k = 0; k < 2; k++) begin
      start_cnt[k] = 0; width_err[k] = 0; busy_miss[k] = 0; stab_err[k] = 0;
      fd_cnt[k] = 0; fd_width_err[k] = 0; held_adrs[k] = '0; held_len[k] = '0;
    end
    prev_start = '0;
    prev_fd    = '0;
    forever begin
      @(negedge aclk);
      for (int k = 0; k < 2; k++) begin
        if (rd_start[k] === 1'b1) begin
          if (start_cnt[k] < 64) begin
            log_adrs[k][start_cnt[k]] = rd_adrs[k];
            log_len[k][start_cnt[k]]  = rd_len[k];
          end
          start_cnt[k] = start_cnt[k] + 1;
          held_adrs[k] = rd_adrs[k];
          held_len[k]  = rd_len[k];
          if (prev_start[k]) width_err[k] = width_err[k] + 1;
          if (busy[k] !== 1'b1) busy_miss[k] = busy_miss[k] + 1;
        end else if (busy[k] === 1'b1) begin
          if (rd_adrs[k] !== held_adrs[k] || rd_len[k] !== held_len[k])
            stab_err[k] = stab_err[k] + 1;
        end
        if (frame_done[k] === 1'b1) begin
          fd_cnt[k] = fd_cnt[k] + 1;
          if (prev_fd[k]) fd_width_err[k] = fd_width_err[k] + 1;
        end
        prev_start[k] = rd_start[k];
        prev_fd[k]    = frame_done[k];
      end
    end
  end

  task automatic wait_starts(input int k, input int target, input int max_cyc, output bit timed_out);
    int c = 0;
    while (start_cnt[k] < target && c < max_cyc) begin
      @(negedge aclk); #1;
      c++;
    end
    timed_out = (start_cnt[k] < target);
  endtask

  task automatic wait_idle(input int k, output bit timed_out);
    int c = 0;
    while (busy[k] !== 1'b0 && c < 200) begin
      @(negedge aclk); #1;
      c++;
    end
    timed_out = (busy[k] !== 1'b0);
    repeat (3) @(negedge aclk);
    #1;
  endtask

  task automatic wait_in_flight(input int k);
    int c = 0;
    while (m_ready[k] !== 1'b0 && c < 20) begin
      @(negedge aclk); #1;
      c++;
    end
    repeat (3) @(negedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    rd_en = '0;
    frame_restart = '0;
    fifo_cnt[0] = '0;
    fifo_cnt[1] = '0;
    repeat (3) @(negedge aclk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (rd_start[k] !== 1'b0 || rd_adrs[k] !== 32'h0 || rd_len[k] !== 10'd64 ||
          frame_done[k] !== 1'b0 || busy[k] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_values[%0d]: got start=%b adrs=%h len=%0d fd=%b busy=%b, expected 0/00000000/64/0/0",
                 k, rd_start[k], rd_adrs[k], rd_len[k], frame_done[k], busy[k]);
      end
    end
    aresetn = 1'b1;
    repeat (5) @(negedge aclk);
    #1;
    n_checks++;
    if (start_cnt[0] + start_cnt[1] !== 0) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got %0d requests, expected 0", start_cnt[0] + start_cnt[1]);
    end
  endtask

  task automatic test_basic_issue();
    bit to;
    rd_en[0] = 1'b1;
    wait_starts(0, 2, 300, to);
    rd_en[0] = 1'b0;
    n_checks++;
    if (to) begin n_fail++; $display("[TB] FAIL basic_timeout: got %0d requests, expected 2", start_cnt[0]); end
    n_checks++;
    if (log_adrs[0][0] !== 32'h0 || log_len[0][0] !== 10'd64) begin
      n_fail++;
      $display("[TB] FAIL basic_first: got adrs=%h len=%0d, expected 00000000/64", log_adrs[0][0], log_len[0][0]);
    end
    n_checks++;
    if (log_adrs[0][1] !== 32'h200 || log_len[0][1] !== 10'd64) begin
      n_fail++;
      $display("[TB] FAIL basic_second: got adrs=%h len=%0d, expected 00000200/64", log_adrs[0][1], log_len[0][1]);
    end
    wait_idle(0, to);
    n_checks++;
    if (to) begin n_fail++; $display("[TB] FAIL basic_idle: busy stuck at %b, expected 0", busy[0]); end
    n_checks++;
    if (width_err[0] !== 0 || busy_miss[0] !== 0) begin
      n_fail++;
      $display("[TB] FAIL basic_start_pulse: got width_err=%0d busy_miss=%0d, expected 0/0", width_err[0], busy_miss[0]);
    end
  endtask

  task automatic test_restart_mid_burst();
    bit to;
    int base = start_cnt[0];
    rd_en[0] = 1'b1;
    wait_starts(0, base + 1, 100, to);
    n_checks++;
    if (to || log_adrs[0][base] !== 32'h400) begin
      n_fail++;
      $display("[TB] FAIL restart_pre_adrs: got %h (timeout=%b), expected 00000400", log_adrs[0][base], to);
    end
    wait_in_flight(0);
    n_checks++;
    if (busy[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_in_flight: got busy=%b, expected 1", busy[0]); end
    frame_restart[0] = 1'b1;
    @(negedge aclk); #1;
    frame_restart[0] = 1'b0;
    wait_starts(0, base + 2, 100, to);
    rd_en[0] = 1'b0;
    n_checks++;
    if (to || log_adrs[0][base+1] !== 32'h0 || log_len[0][base+1] !== 10'd64) begin
      n_fail++;
      $display("[TB] FAIL restart_next: got adrs=%h len=%0d (timeout=%b), expected 00000000/64",
               log_adrs[0][base+1], log_len[0][base+1], to);
    end
    wait_idle(0, to);
    n_checks++;
    if (stab_err[0] !== 0) begin n_fail++; $display("[TB] FAIL restart_len_stable: got %0d changes, expected 0", stab_err[0]); end
  endtask

  task automatic test_fifo_full();
    bit to;
    int lat = 0;
    int base = start_cnt[0];
    fifo_cnt[0] = 11'd961;
    rd_en[0] = 1'b1;
    repeat (50) @(negedge aclk);
    #1;
    n_checks++;
    if (start_cnt[0] !== base) begin
      n_fail++;
      $display("[TB] FAIL fifo_full_block: got %0d requests, expected 0", start_cnt[0] - base);
    end
    fifo_cnt[0] = 11'd960;
    while (rd_start[0] !== 1'b1 && lat < 5) begin
      @(posedge aclk); #1;
      lat++;
    end
    n_checks++;
    if (rd_start[0] !== 1'b1 || lat < 1 || lat > 2) begin
      n_fail++;
      $display("[TB] FAIL fifo_room_latency: got start=%b after %0d edges, expected 1 within 1..2", rd_start[0], lat);
    end
    rd_en[0] = 1'b0;
    fifo_cnt[0] = 11'd0;
    @(negedge aclk); #1;
    n_checks++;
    if (log_adrs[0][base] !== 32'h200) begin
      n_fail++;
      $display("[TB] FAIL fifo_room_adrs: got %h, expected 00000200", log_adrs[0][base]);
    end
    wait_idle(0, to);
  endtask

  task automatic test_rd_en_low();
    bit to;
    int base = start_cnt[0];
    fifo_cnt[0] = 11'd0;
    rd_en[0] = 1'b0;
    repeat (200) @(negedge aclk);
    #1;
    n_checks++;
    if (start_cnt[0] !== base) begin
      n_fail++;
      $display("[TB] FAIL rd_en_block: got %0d requests, expected 0", start_cnt[0] - base);
    end
    rd_en[0] = 1'b1;
    wait_starts(0, base + 1, 50, to);
    n_checks++;
    if (to || log_adrs[0][base] !== 32'h400 || log_len[0][base] !== 10'd64) begin
      n_fail++;
      $display("[TB] FAIL rd_en_resume: got adrs=%h len=%0d (timeout=%b), expected 00000400/64",
               log_adrs[0][base], log_len[0][base], to);
    end
  endtask

  task automatic test_async_reset();
    bit to;
    int base;
    wait_in_flight(0);
    n_checks++;
    if (busy[0] !== 1'b1 || rd_adrs[0] !== 32'h400) begin
      n_fail++;
      $display("[TB] FAIL areset_pre: got busy=%b adrs=%h, expected 1/00000400", busy[0], rd_adrs[0]);
    end
    #1;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (rd_start[0] !== 1'b0 || rd_adrs[0] !== 32'h0 || rd_len[0] !== 10'd64 ||
        frame_done[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL areset_outputs: got start=%b adrs=%h len=%0d fd=%b busy=%b, expected 0/00000000/64/0/0",
               rd_start[0], rd_adrs[0], rd_len[0], frame_done[0], busy[0]);
    end
    repeat (2) @(negedge aclk);
    #1;
    aresetn = 1'b1;
    base = start_cnt[0];
    wait_starts(0, base + 1, 50, to);
    rd_en[0] = 1'b0;
    n_checks++;
    if (to || log_adrs[0][base] !== 32'h0 || log_len[0][base] !== 10'd64) begin
      n_fail++;
      $display("[TB] FAIL areset_first_burst: got adrs=%h len=%0d (timeout=%b), expected 00000000/64",
               log_adrs[0][base], log_len[0][base], to);
    end
    wait_idle(0, to);
  endtask

  task automatic test_partial_burst();
    bit to;
    rd_en[1] = 1'b1;
    wait_starts(1, 3, 200, to);
    rd_en[1] = 1'b0;
    n_checks++;
    if (to) begin n_fail++; $display("[TB] FAIL partial_timeout: got %0d requests, expected 3", start_cnt[1]); end
    n_checks++;
    if (log_adrs[1][0] !== 32'h0 || log_len[1][0] !== 10'd64) begin
      n_fail++;
      $display("[TB] FAIL partial_first: got adrs=%h len=%0d, expected 00000000/64", log_adrs[1][0], log_len[1][0]);
    end
    n_checks++;
    if (log_adrs[1][1] !== 32'h200 || log_len[1][1] !== 10'd36) begin
      n_fail++;
      $display("[TB] FAIL partial_last: got adrs=%h len=%0d, expected 00000200/36", log_adrs[1][1], log_len[1][1]);
    end
    n_checks++;
    if (fd_cnt[1] !== 1) begin n_fail++; $display("[TB] FAIL partial_frame_done: got %0d pulses, expected 1", fd_cnt[1]); end
    n_checks++;
    if (log_adrs[1][2] !== 32'h0 || log_len[1][2] !== 10'd64) begin
      n_fail++;
      $display("[TB] FAIL partial_wrap: got adrs=%h len=%0d, expected 00000000/64", log_adrs[1][2], log_len[1][2]);
    end
    wait_idle(1, to);
    n_checks++;
    if (fd_width_err[1] !== 0 || fd_cnt[0] !== 0 || width_err[1] !== 0 || stab_err[1] !== 0) begin
      n_fail++;
      $display("[TB] FAIL partial_pulses: got fd_width=%0d fd_full=%0d start_width=%0d stab=%0d, expected 0/0/0/0",
               fd_width_err[1], fd_cnt[0], width_err[1], stab_err[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_restart_mid_burst();
    test_fifo_full();
    test_rd_en_low();
    test_async_reset();
    test_partial_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
